uart_rx_frame: RTL and testbench
================================

# uart_rx_frame

Parametrised UART receive block with configurable frame format: 5–9 data bits, optional odd/even parity, 1 or 2 stop bits, and a fixed oversampling ratio. It sits between the asynchronous serial pin and the on-chip consumer. It delivers each received word through a valid/ready holding register and reports parity, framing and overrun errors. It supersedes the fixed 8N1 receiver and adds input synchronisation, glitch rejection, parity, error reporting and back-pressure.

## Interface
- CLKS_PER_BIT, 16: clk cycles per serial bit; even, ≥ 8.
- DATA_BITS, 8: data bits per frame, 5..9, LSB first.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- data_in  in  1  serial line, idle high, asynchronous to clk.
- data_out  out  DATA_BITS  received word, valid while data_valid = 1.
- data_valid  out  1  holding register full.
- data_ready  in  1  consumer accepts word when data_valid & data_ready.
- parity_err  out  1  one-cycle pulse, parity mismatch on completed frame.
- frame_err  out  1  one-cycle pulse, a stop bit sampled low.
- overrun_err  out  1  one-cycle pulse, frame completed while holding register full and not drained.

## Operation
- data_in passes a 2-flop synchroniser (reset to 1); all decisions use the synchronised line `rx_s`.
- States:
  - IDLE: `rx_s` = 0 → START, counter cleared.
  - START: at counter = CLKS_PER_BIT/2−1, `rx_s` = 0 → DATA (counter and bit index cleared); `rx_s` = 1 → IDLE (glitch, nothing reported).
  - DATA: sample every CLKS_PER_BIT cycles (counter = CLKS_PER_BIT−1, then clear); shift LSB first. After DATA_BITS samples → PARITY if PARITY ≠ 0, else STOP.
  - PARITY: one sample. Odd: XOR(data, parity bit) must be 1. Even: it must be 0.
  - STOP: STOP_BITS samples, each must be 1. After the last sample: if any stop sample was 0 → WAIT_HIGH, else IDLE.
  - WAIT_HIGH: stay until `rx_s` = 1, then → IDLE. This prevents a break or line-low condition from retriggering a start.
- Completion happens on the last stop-sample cycle; effects are registered on the following edge:
  - Framing error: frame_err pulses; data is not delivered; no overrun check.
  - Good stop, holding register empty or drained this cycle: data_out loads, data_valid = 1. parity_err pulses if parity failed; the data is still delivered.
  - Good stop, data_valid = 1 and data_ready = 0: overrun_err pulses; new word discarded; data_out/data_valid unchanged. parity_err is not raised for the discarded word.
- Handshake: data_valid & data_ready clears data_valid on the next edge, unless a new word loads on that same edge, in which case data_valid stays 1 with the new word. data_out is held stable while data_valid = 1.
- Bits above DATA_BITS do not exist; data_out width tracks DATA_BITS exactly.

## Timing
- Reset values: data_out = 0, data_valid = 0, parity_err = frame_err = overrun_err = 0; state IDLE, counters 0, synchroniser 1.
- Reset is asynchronous in any state. A frame in progress is abandoned and never reported.
- Synchroniser latency: 2 clk.
- Sample points: START sample CLKS_PER_BIT/2 cycles after entering START; each subsequent sample CLKS_PER_BIT cycles later (mid-bit).
- Pin falling edge to data_valid: 2 + 1 + CLKS_PER_BIT/2 + (DATA_BITS + (PARITY≠0) + STOP_BITS)·CLKS_PER_BIT + 1 cycles, ±1 for pin-to-clk phase.
- Back-to-back frames are supported. After STOP the receiver is in IDLE in time to catch a start bit beginning half a bit after the last stop sample.
- Error pulses are exactly one cycle wide and are coincident with the edge on which data_valid would load.

## Configuration
- UART_RX_MAJORITY_EN defined:
  - Every bit decision (START, DATA, PARITY, STOP) is the 2-of-3 majority of `rx_s` at counter = mid−1, mid, mid+1, taken at the original sample point plus one cycle.
  - All sample points and the total latency shift by +1 cycle.
  - Requires CLKS_PER_BIT ≥ 8.
- Undefined: single sample at the mid-bit point as above.

## Test plan
- 8N1, CLKS_PER_BIT = 16, send 0xA5, data_ready = 1: data_valid pulses once with data_out = 0xA5; all error outputs 0; latency matches the Timing formula.
- DATA_BITS = 7, PARITY = 2 (even), send 0x35 with parity bit 1 (wrong): data_out = 0x35, data_valid = 1, parity_err pulses one cycle. Resend with parity bit 0 (correct): no parity_err.
- 8N2, send 0x3C with second stop bit 0, then hold line low 40 bits, then release: frame_err pulses once, data_valid stays 0, no further frames until the line returns high.
- Line low for 3 cycles in idle: no data_valid and no errors; state returns to IDLE.
- Two back-to-back frames 0x11 then 0x22 with data_ready = 0: data_out = 0x11 held; overrun_err pulses at second completion. Then data_ready = 1 for one cycle: data_valid falls.
- rst_n low during the 4th data bit of 0xFF: all outputs 0 immediately. After release, a clean 0x42 frame is received correctly.

Source files
------------

// File: rtl/uart_rx_frame.sv
// UART receiver with configurable frame format (5-9 data bits, none/odd/even
// parity, 1 or 2 stop bits), 2-flop input synchroniser, glitch-rejecting start
// detection, valid/ready holding register and parity/framing/overrun pulses.
// Optional build macro UART_RX_MAJORITY_EN: each bit decision becomes a 2-of-3
// vote around the mid-bit point, taken one cycle after the nominal sample.
module uart_rx_frame #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 data_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
`ifdef UART_RX_MAJORITY_EN
  localparam int unsigned MajDly = 1;
`else
  localparam int unsigned MajDly = 0;
`endif
  localparam logic [CntW-1:0] StartSample = CntW'(CLKS_PER_BIT / 2 - 1 + MajDly);
  localparam logic [CntW-1:0] BitSample   = CntW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]      LastData    = 4'(DATA_BITS - 1);
  localparam logic [3:0]      LastStop    = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    StIdle, StStart, StData, StParity, StStop, StWaitHigh
  } state_e;

  logic [1:0]           sync_q;
  logic                 rx_s;
  logic                 rx_bit;
  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [3:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bit_q, par_bit_d;
  logic                 stop_bad_q, stop_bad_d;
  logic                 done_good, done_bad, par_fail;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d, ferr_q, ferr_d, oerr_q, oerr_d;

  // Two-flop synchroniser for the asynchronous serial pin; idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], data_in};
  end
  assign rx_s = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q;
  // Two previous line samples; with rx_s they form the three-sample vote window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist_q <= 2'b11;
    else        hist_q <= {hist_q[0], rx_s};
  end
  assign rx_bit = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
  assign rx_bit = rx_s;
`endif

  // Frame state and shift registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      par_bit_q  <= 1'b0;
      stop_bad_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      par_bit_q  <= par_bit_d;
      stop_bad_q <= stop_bad_d;
    end
  end

  // Next-state logic; completion is flagged on the last stop-sample cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CntW'(1);
    idx_d      = idx_q;
    shift_d    = shift_q;
    par_bit_d  = par_bit_q;
    stop_bad_d = stop_bad_q;
    done_good  = 1'b0;
    done_bad   = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!rx_s) state_d = StStart;
      end
      StStart: begin
        if (cnt_q == StartSample) begin
          cnt_d      = '0;
          idx_d      = '0;
          stop_bad_d = 1'b0;
          state_d    = rx_bit ? StIdle : StData;  // high at mid-start is a glitch
        end
      end
      StData: begin
        if (cnt_q == BitSample) begin
          cnt_d   = '0;
          shift_d = {rx_bit, shift_q[DATA_BITS-1:1]};
          if (idx_q == LastData) begin
            idx_d   = '0;
            state_d = (PARITY != 0) ? StParity : StStop;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      StParity: begin
        if (cnt_q == BitSample) begin
          cnt_d     = '0;
          par_bit_d = rx_bit;
          state_d   = StStop;
        end
      end
      StStop: begin
        if (cnt_q == BitSample) begin
          cnt_d = '0;
          if (idx_q == LastStop) begin
            idx_d = '0;
            if (stop_bad_q || !rx_bit) begin
              done_bad = 1'b1;
              state_d  = StWaitHigh;
            end else begin
              done_good = 1'b1;
              state_d   = StIdle;
            end
          end else begin
            idx_d      = idx_q + 4'd1;
            stop_bad_d = stop_bad_q | ~rx_bit;
          end
        end
      end
      StWaitHigh: begin
        // Hold off until the line idles so a break cannot retrigger a start.
        cnt_d = '0;
        if (rx_s) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Parity check over the assembled word and the received parity bit.
  always_comb begin
    par_fail = 1'b0;
    if (PARITY == 1)      par_fail = ~(^shift_q ^ par_bit_q);
    else if (PARITY == 2) par_fail = ^shift_q ^ par_bit_q;
  end

  // Holding register, handshake and error pulse generation.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q & ~data_ready;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;
    oerr_d  = 1'b0;
    if (done_bad) begin
      ferr_d = 1'b1;
    end else if (done_good) begin
      if (!valid_q || data_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
        perr_d  = par_fail;
      end else begin
        oerr_d = 1'b1;  // new word dropped, held word untouched
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      oerr_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      oerr_q  <= oerr_d;
    end
  end

  assign data_out    = data_q;
  assign data_valid  = valid_q;
  assign parity_err  = perr_q;
  assign frame_err   = ferr_q;
  assign overrun_err = oerr_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: three instances (8N1, 7E1, 8N2) driven by
// bit-level serial tasks; pulse counters on the falling clock edge.
module tb_uart_rx_frame;

  localparam int unsigned Cpb = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic line_a = 1'b1, line_b = 1'b1, line_c = 1'b1;
  logic rdy_a = 1'b0, rdy_b = 1'b0, rdy_c = 1'b0;
  logic [7:0] dout_a, dout_c;
  logic [6:0] dout_b;
  logic valid_a, valid_b, valid_c;
  logic perr_a, perr_b, perr_c, ferr_a, ferr_b, ferr_c, oerr_a, oerr_b, oerr_c;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  uart_rx_frame #(.CLKS_PER_BIT(Cpb), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst_n(rst_n), .data_in(line_a), .data_out(dout_a), .data_valid(valid_a),
    .data_ready(rdy_a), .parity_err(perr_a), .frame_err(ferr_a), .overrun_err(oerr_a)
  );
  uart_rx_frame #(.CLKS_PER_BIT(Cpb), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u_7e1 (
    .clk(clk), .rst_n(rst_n), .data_in(line_b), .data_out(dout_b), .data_valid(valid_b),
    .data_ready(rdy_b), .parity_err(perr_b), .frame_err(ferr_b), .overrun_err(oerr_b)
  );
  uart_rx_frame #(.CLKS_PER_BIT(Cpb), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_8n2 (
    .clk(clk), .rst_n(rst_n), .data_in(line_c), .data_out(dout_c), .data_valid(valid_c),
    .data_ready(rdy_c), .parity_err(perr_c), .frame_err(ferr_c), .overrun_err(oerr_c)
  );

  // Event counters: valid rising edges and error-high cycles per instance.
  int cyc = 0, t_valid_a = 0;
  int vr_a = 0, vr_b = 0, vr_c = 0;
  int pe_a = 0, pe_b = 0, pe_c = 0, fe_a = 0, fe_b = 0, fe_c = 0;
  int oe_a = 0, oe_b = 0, oe_c = 0;
  logic pv_a = 1'b0, pv_b = 1'b0, pv_c = 1'b0;
  logic [7:0] cap_a = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid_a && !pv_a) begin
      vr_a      <= vr_a + 1;
      t_valid_a <= cyc;
      cap_a     <= dout_a;
    end
    if (valid_b && !pv_b) vr_b <= vr_b + 1;
    if (valid_c && !pv_c) vr_c <= vr_c + 1;
    pv_a <= valid_a;
    pv_b <= valid_b;
    pv_c <= valid_c;
    pe_a <= pe_a + int'(perr_a);
    pe_b <= pe_b + int'(perr_b);
    pe_c <= pe_c + int'(perr_c);
    fe_a <= fe_a + int'(ferr_a);
    fe_b <= fe_b + int'(ferr_b);
    fe_c <= fe_c + int'(ferr_c);
    oe_a <= oe_a + int'(oerr_a);
    oe_b <= oe_b + int'(oerr_b);
    oe_c <= oe_c + int'(oerr_c);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_line(input int which, input logic v);
    case (which)
      0:       line_a = v;
      1:       line_b = v;
      default: line_c = v;
    endcase
  endtask

  task automatic send_bit(input int which, input logic v);
    set_line(which, v);
    tick(Cpb);
  endtask

  // Start bit, LSB-first data, optional parity bit, stop bits (last one configurable).
  task automatic send_frame(input int which, input logic [8:0] data, input int nbits,
                            input bit has_par, input logic par, input int nstops,
                            input logic last_stop);
    logic [8:0] d;
    d = data;
    send_bit(which, 1'b0);
    for (int i = 0; i < nbits; i++) send_bit(which, d[i]);
    if (has_par) send_bit(which, par);
    for (int s = 0; s < nstops; s++) send_bit(which, (s == nstops - 1) ? last_stop : 1'b1);
  endtask

  task automatic test_reset;
    tick(3);
    n_tests++;
    if ({dout_a, valid_a, perr_a, ferr_a, oerr_a} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_a: got %h %b%b%b%b, expected 00 0000", dout_a, valid_a, perr_a,
               ferr_a, oerr_a);
    end
    n_tests++;
    if ({dout_b, valid_b, perr_b, ferr_b, oerr_b} !== 11'h000) begin
      n_fail++;
      $display("FAIL reset_b: got %h %b, expected 00 0", dout_b, valid_b);
    end
    n_tests++;
    if ({dout_c, valid_c, perr_c, ferr_c, oerr_c} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_c: got %h %b, expected 00 0", dout_c, valid_c);
    end
    rst_n = 1'b1;
    tick(4);
  endtask

  task automatic test_8n1;
    int v0, e0, t0, lat;
    rdy_a = 1'b1;
    v0 = vr_a;
    e0 = pe_a + fe_a + oe_a;
    t0 = cyc;
    send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1, 1'b1);
    tick(4);
    lat = t_valid_a - t0;
    n_tests++;
    if (vr_a - v0 !== 1) begin
      n_fail++;
      $display("FAIL 8n1_valid_count: got %0d, expected 1", vr_a - v0);
    end
    n_tests++;
    if (cap_a !== 8'hA5) begin
      n_fail++;
      $display("FAIL 8n1_data: got %h, expected a5", cap_a);
    end
    n_tests++;
    if (pe_a + fe_a + oe_a - e0 !== 0) begin
      n_fail++;
      $display("FAIL 8n1_errors: got %0d, expected 0", pe_a + fe_a + oe_a - e0);
    end
    // 2 + 1 + 8 + 9*16 + 1 = 156 cycles, +/-1 for pin phase
    n_tests++;
    if (lat < 155 || lat > 157) begin
      n_fail++;
      $display("FAIL 8n1_latency: got %0d, expected 155..157", lat);
    end
    n_tests++;
    if (valid_a !== 1'b0) begin
      n_fail++;
      $display("FAIL 8n1_drained: got %b, expected 0", valid_a);
    end
  endtask

  task automatic test_parity;
    int p0, v0;
    rdy_b = 1'b0;
    p0 = pe_b;
    v0 = vr_b;
    // 0x35 has four ones: correct even parity bit is 0, send 1
    send_frame(1, 9'h035, 7, 1'b1, 1'b1, 1, 1'b1);
    tick(4);
    n_tests++;
    if (dout_b !== 7'h35 || valid_b !== 1'b1) begin
      n_fail++;
      $display("FAIL par_bad_data: got %h v=%b, expected 35 v=1", dout_b, valid_b);
    end
    n_tests++;
    if (pe_b - p0 !== 1) begin
      n_fail++;
      $display("FAIL par_bad_pulse: got %0d cycles, expected 1", pe_b - p0);
    end
    rdy_b = 1'b1;
    tick(1);
    rdy_b = 1'b0;
    n_tests++;
    if (valid_b !== 1'b0) begin
      n_fail++;
      $display("FAIL par_drain: got %b, expected 0", valid_b);
    end
    p0 = pe_b;
    send_frame(1, 9'h035, 7, 1'b1, 1'b0, 1, 1'b1);
    tick(4);
    n_tests++;
    if (dout_b !== 7'h35 || valid_b !== 1'b1 || vr_b - v0 !== 2) begin
      n_fail++;
      $display("FAIL par_good_data: got %h v=%b n=%0d, expected 35 v=1 n=2", dout_b, valid_b,
               vr_b - v0);
    end
    n_tests++;
    if (pe_b - p0 !== 0) begin
      n_fail++;
      $display("FAIL par_good_pulse: got %0d, expected 0", pe_b - p0);
    end
    rdy_b = 1'b1;
    tick(1);
    rdy_b = 1'b0;
  endtask

  task automatic test_framing;
    int f0, v0;
    rdy_c = 1'b0;
    f0 = fe_c;
    v0 = vr_c;
    send_frame(2, 9'h03C, 8, 1'b0, 1'b0, 2, 1'b0);
    tick(40 * Cpb);
    n_tests++;
    if (fe_c - f0 !== 1) begin
      n_fail++;
      $display("FAIL frame_pulse: got %0d cycles, expected 1", fe_c - f0);
    end
    n_tests++;
    if (vr_c - v0 !== 0 || valid_c !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_no_data: got %0d v=%b, expected 0 v=0", vr_c - v0, valid_c);
    end
    set_line(2, 1'b1);
    tick(2 * Cpb);
    n_tests++;
    if (fe_c - f0 !== 1 || vr_c - v0 !== 0) begin
      n_fail++;
      $display("FAIL frame_after_release: got fe=%0d v=%0d, expected 1 0", fe_c - f0, vr_c - v0);
    end
    send_frame(2, 9'h05A, 8, 1'b0, 1'b0, 2, 1'b1);
    tick(4);
    n_tests++;
    if (dout_c !== 8'h5A || valid_c !== 1'b1 || fe_c - f0 !== 1) begin
      n_fail++;
      $display("FAIL frame_recover: got %h v=%b fe=%0d, expected 5a v=1 fe=1", dout_c, valid_c,
               fe_c - f0);
    end
    rdy_c = 1'b1;
    tick(1);
    rdy_c = 1'b0;
  endtask

  task automatic test_glitch;
    int v0, e0;
    rdy_a = 1'b1;
    v0 = vr_a;
    e0 = pe_a + fe_a + oe_a;
    set_line(0, 1'b0);
    tick(3);
    set_line(0, 1'b1);
    tick(2 * Cpb);
    n_tests++;
    if (vr_a - v0 !== 0 || valid_a !== 1'b0 || pe_a + fe_a + oe_a - e0 !== 0) begin
      n_fail++;
      $display("FAIL glitch_quiet: got v=%0d err=%0d, expected 0 0", vr_a - v0,
               pe_a + fe_a + oe_a - e0);
    end
    send_frame(0, 9'h03C, 8, 1'b0, 1'b0, 1, 1'b1);
    tick(4);
    n_tests++;
    if (vr_a - v0 !== 1 || cap_a !== 8'h3C) begin
      n_fail++;
      $display("FAIL glitch_then_frame: got n=%0d %h, expected 1 3c", vr_a - v0, cap_a);
    end
  endtask

  task automatic test_back_to_back;
    int v0, o0, p0;
    rdy_a = 1'b0;
    v0 = vr_a;
    o0 = oe_a;
    p0 = pe_a;
    send_frame(0, 9'h011, 8, 1'b0, 1'b0, 1, 1'b1);
    send_frame(0, 9'h022, 8, 1'b0, 1'b0, 1, 1'b1);
    tick(4);
    n_tests++;
    if (dout_a !== 8'h11 || valid_a !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_held: got %h v=%b, expected 11 v=1", dout_a, valid_a);
    end
    n_tests++;
    if (oe_a - o0 !== 1 || vr_a - v0 !== 1 || pe_a - p0 !== 0) begin
      n_fail++;
      $display("FAIL b2b_overrun: got oe=%0d v=%0d pe=%0d, expected 1 1 0", oe_a - o0,
               vr_a - v0, pe_a - p0);
    end
    rdy_a = 1'b1;
    tick(1);
    rdy_a = 1'b0;
    n_tests++;
    if (valid_a !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain: got %b, expected 0", valid_a);
    end
  endtask

  task automatic test_reset_midframe;
    int v0, e0;
    rdy_a = 1'b0;
    send_frame(0, 9'h05A, 8, 1'b0, 1'b0, 1, 1'b1);
    tick(4);
    n_tests++;
    if (valid_a !== 1'b1 || dout_a !== 8'h5A) begin
      n_fail++;
      $display("FAIL rst_pre: got %h v=%b, expected 5a v=1", dout_a, valid_a);
    end
    // 0xFF frame: start bit, then bits 0..2 and half of bit 3
    set_line(0, 1'b0);
    tick(Cpb);
    set_line(0, 1'b1);
    tick(3 * Cpb + 8);
    rst_n = 1'b0;
    #2;
    n_tests++;
    if ({dout_a, valid_a, perr_a, ferr_a, oerr_a} !== 12'h000) begin
      n_fail++;
      $display("FAIL rst_async: got %h %b%b%b%b, expected 00 0000", dout_a, valid_a, perr_a,
               ferr_a, oerr_a);
    end
    tick(2);
    rst_n = 1'b1;
    v0 = vr_a;
    e0 = pe_a + fe_a + oe_a;
    tick(12 * Cpb);
    n_tests++;
    if (vr_a - v0 !== 0 || pe_a + fe_a + oe_a - e0 !== 0) begin
      n_fail++;
      $display("FAIL rst_abandon: got v=%0d err=%0d, expected 0 0", vr_a - v0,
               pe_a + fe_a + oe_a - e0);
    end
    rdy_a = 1'b1;
    send_frame(0, 9'h042, 8, 1'b0, 1'b0, 1, 1'b1);
    tick(4);
    n_tests++;
    if (vr_a - v0 !== 1 || cap_a !== 8'h42 || pe_a + fe_a + oe_a - e0 !== 0) begin
      n_fail++;
      $display("FAIL rst_recover: got n=%0d %h, expected 1 42", vr_a - v0, cap_a);
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_framing();
    test_glitch();
    test_back_to_back();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
